// File: rtl/serdes_pkg.sv
// Shared width/ratio derivation for the serializer and deserializer pair.
// Every helper takes the beat and word log2 widths and returns an elaboration-time constant.
package serdes_pkg;

  // Beats per word.
  function automatic int ratio(input int in_log, input int out_log);
    return 1 << (out_log - in_log);
  endfunction

  // Width of the beat index counter.
  function automatic int cnt_width(input int in_log, input int out_log);
    return out_log - in_log;
  endfunction

  // Index of the beat that completes a word.
  function automatic int max_cnt(input int in_log, input int out_log);
    return ratio(in_log, out_log) - 1;
  endfunction

endpackage

// File: rtl/deserializer.sv
// LSB-first beat-to-word deserializer with a single registered output word.
// Optional packet flush (in_last/out_last) is enabled by defining DESERIALIZER_FLUSH_EN.
module deserializer
  import serdes_pkg::*;
#(
  parameter int INLOGBITS  = 3,
  parameter int OUTLOGBITS = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [(1 << INLOGBITS)-1:0]  in_data,
`ifdef DESERIALIZER_FLUSH_EN
  input  logic                         in_last,
  output logic                         out_last,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [(1 << OUTLOGBITS)-1:0] out_data
);

  localparam int INWIDTH  = 1 << INLOGBITS;
  localparam int OUTWIDTH = 1 << OUTLOGBITS;
  localparam int RATIO    = ratio(INLOGBITS, OUTLOGBITS);
  localparam int CNTW     = cnt_width(INLOGBITS, OUTLOGBITS);
  localparam logic [CNTW-1:0] MAXCNT = CNTW'(max_cnt(INLOGBITS, OUTLOGBITS));
  localparam int ACCW     = OUTWIDTH - INWIDTH;

  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [ACCW-1:0]     acc_q, acc_d;
  logic                out_valid_q, out_valid_d;
  logic [OUTWIDTH-1:0] out_data_q, out_data_d;
  logic [OUTWIDTH-1:0] new_word;
  logic                last_beat;
  logic                word_end;
  logic                in_fire;
  logic                out_fire;

`ifdef DESERIALIZER_FLUSH_EN
  logic out_last_q, out_last_d;
  assign last_beat = in_last;
  assign out_last  = out_last_q;
`else
  assign last_beat = 1'b0;
`endif

  // A completing beat may only enter when the output register is free or draining now.
  assign word_end  = (cnt_q == MAXCNT) || last_beat;
  assign in_ready  = !reset && (!word_end || !out_valid_q || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Lanes below cnt come from the accumulator, lane cnt is the incoming beat, lanes above are zero.
  always_comb begin
    new_word = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (CNTW'(k) < cnt_q) begin
        new_word[k*INWIDTH +: INWIDTH] = acc_q[k*INWIDTH +: INWIDTH];
      end else if (CNTW'(k) == cnt_q) begin
        new_word[k*INWIDTH +: INWIDTH] = in_data;
      end
    end
    if (cnt_q == MAXCNT) begin
      new_word[OUTWIDTH-1 -: INWIDTH] = in_data;
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef DESERIALIZER_FLUSH_EN
    out_last_d  = out_last_q;
`endif

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      if (word_end) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = new_word;
`ifdef DESERIALIZER_FLUSH_EN
        out_last_d  = in_last;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
        for (int k = 0; k < RATIO - 1; k++) begin
          if (CNTW'(k) == cnt_q) begin
            acc_d[k*INWIDTH +: INWIDTH] = in_data;
          end
        end
      end
    end
  end

  // NOTE: the accumulator is reset along with the control state so a discarded partial word
  // can never leak into a later output.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
    if (reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef DESERIALIZER_FLUSH_EN
      out_last_q  <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef DESERIALIZER_FLUSH_EN
      out_last_q  <= out_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed vectors plus a queue-based packing model.
// Define DESERIALIZER_FLUSH_EN to also exercise the packet flush feature.
`timescale 1ns/1ps
module tb_deserializer;

  localparam int INW   = 8;
  localparam int OUTW  = 32;
  localparam int RATIO = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [INW-1:0]  in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [OUTW-1:0] out_data;
`ifdef DESERIALIZER_FLUSH_EN
  logic            in_last = 1'b0;
  logic            out_last;
`endif

  int checks   = 0;
  int failures = 0;
  int stall_cnt = 0;

  // Model state: beats collected for the word in progress and the expected output register.
  bit [INW-1:0]    m_beats[$];
  bit              m_valid = 1'b0;
  logic [OUTW-1:0] m_data  = '0;
  bit              m_last  = 1'b0;

  // Handshake logs for end-to-end packing comparison.
  bit [INW-1:0]    acc_log[$];
  logic [OUTW-1:0] got[$];

  always #5 clk = ~clk;

  deserializer #(.INLOGBITS(3), .OUTLOGBITS(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef DESERIALIZER_FLUSH_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUTW-1:0] pack(input bit [INW-1:0] q[$]);
    logic [OUTW-1:0] w = '0;
    foreach (q[i]) w = w | (OUTW'(q[i]) << (i * INW));
    return w;
  endfunction

  // Per-cycle compare and model update, away from the active edge.
  initial begin
    bit lst;
    bit rdy;
    @(posedge clk);
    forever begin
      @(negedge clk);
`ifdef DESERIALIZER_FLUSH_EN
      lst = in_last;
`else
      lst = 1'b0;
`endif
      rdy = !reset && ((m_beats.size() < RATIO - 1 && !lst) || !m_valid || out_ready);
      check("mon_in_ready", in_ready, rdy);
      check("mon_out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("mon_out_data", out_data, m_data);
`ifdef DESERIALIZER_FLUSH_EN
        check("mon_out_last", out_last, m_last);
`endif
      end
      if (!reset) begin
        if (in_valid && in_ready) acc_log.push_back(in_data);
        if (out_valid && out_ready) got.push_back(out_data);
      end
      if (reset) begin
        m_beats.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (in_valid && rdy) begin
          m_beats.push_back(in_data);
          if (m_beats.size() == RATIO || lst) begin
            m_data  = pack(m_beats);
            m_valid = 1'b1;
            m_last  = lst;
            m_beats.delete();
          end
        end
      end
    end
  end

  // Holds in_valid with d until accepted; returns 1 ns after the accepting edge.
  task automatic send_beat(input logic [INW-1:0] d);
    int  n = 0;
    bit  took = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!took && n < 200) begin
      @(negedge clk);
      took = in_ready;
      if (!took) stall_cnt++;
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) check("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cyc;
    bit [INW-1:0] tmp[$];

    tick(2);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", in_ready, 1'b0);
    reset     = 1'b0;
    out_ready = 1'b1;

    // Four back-to-back beats, word visible exactly one cycle after the last.
    send_beat(8'h11);
    send_beat(8'h22);
    send_beat(8'h33);
    check("t1_not_early", out_valid, 1'b0);
    send_beat(8'h44);
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_data, 32'h44332211);
    tick(1);
    check("t1_one_cycle", out_valid, 1'b0);
    check("t1_drained_cnt", got.size(), 1);
    check("t1_drained_word", got[0], 32'h44332211);

    // Eight continuous beats, no stall.
    got.delete();
    stall_cnt = 0;
    for (int i = 1; i <= 8; i++) send_beat(INW'(i));
    tick(2);
    check("t2_no_stall", stall_cnt, 0);
    check("t2_word_cnt", got.size(), 2);
    check("t2_word0", got[0], 32'h04030201);
    check("t2_word1", got[1], 32'h08070605);

    // Backpressure: first word pending, three beats accepted, fourth held.
    got.delete();
    out_ready = 1'b0;
    send_beat(8'h11);
    send_beat(8'h22);
    send_beat(8'h33);
    send_beat(8'h44);
    send_beat(8'h55);
    send_beat(8'h66);
    send_beat(8'h77);
    in_valid = 1'b1;
    in_data  = 8'h88;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_held_ready", in_ready, 1'b0);
      check("t3_stable_valid", out_valid, 1'b1);
      check("t3_stable_data", out_data, 32'h44332211);
    end
    tick(1);
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_ready_back", in_ready, 1'b1);
    tick(1);
    in_valid = 1'b0;
    check("t3_reload_valid", out_valid, 1'b1);
    check("t3_reload_data", out_data, 32'h88776655);
    check("t3_first_drained", got.size(), 1);
    check("t3_first_word", got[0], 32'h44332211);
    tick(1);
    check("t3_empty", out_valid, 1'b0);

    // Reset mid-word discards the partial beats.
    send_beat(8'hAA);
    send_beat(8'hBB);
    reset = 1'b1;
    @(negedge clk);
    check("t4_rst_ready", in_ready, 1'b0);
    tick(1);
    reset = 1'b0;
    check("t4_rst_valid", out_valid, 1'b0);
    got.delete();
    for (int i = 1; i <= 4; i++) send_beat(INW'(i));
    tick(2);
    check("t4_word_cnt", got.size(), 1);
    check("t4_word", got[0], 32'h04030201);

`ifdef DESERIALIZER_FLUSH_EN
    // Short packet flush, then a normal word.
    send_beat(8'h11);
    in_last = 1'b1;
    send_beat(8'h22);
    in_last = 1'b0;
    check("t5_flush_valid", out_valid, 1'b1);
    check("t5_flush_data", out_data, 32'h00002211);
    check("t5_flush_last", out_last, 1'b1);
    send_beat(8'h33);
    send_beat(8'h44);
    send_beat(8'h55);
    send_beat(8'h66);
    check("t5_full_data", out_data, 32'h66554433);
    check("t5_full_last", out_last, 1'b0);
    // in_last on the final lane still yields a full word.
    send_beat(8'h01);
    send_beat(8'h02);
    send_beat(8'h03);
    in_last = 1'b1;
    send_beat(8'h04);
    in_last = 1'b0;
    check("t5_maxlast_data", out_data, 32'h04030201);
    check("t5_maxlast_last", out_last, 1'b1);
    // in_last beat at lane 0 is held while the output word is stuck.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_beat(INW'(i));
    in_last  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h05;
    @(negedge clk);
    check("t5_last_held", in_ready, 1'b0);
    tick(1);
    out_ready = 1'b1;
    send_beat(8'h05);
    in_last = 1'b0;
    check("t5_single_data", out_data, 32'h00000005);
    check("t5_single_last", out_last, 1'b1);
    tick(2);
`endif

    // Random throttling on both sides, 1000 beats against the packing model.
    acc_log.delete();
    got.delete();
    cyc = 0;
    while (acc_log.size() < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = INW'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick(1);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(4);
    check("t6_beats", acc_log.size(), 1000);
    check("t6_words", got.size(), 250);
    for (int w = 0; w < 250 && w < got.size() && (w * RATIO + RATIO) <= acc_log.size(); w++) begin
      tmp.delete();
      for (int b = 0; b < RATIO; b++) tmp.push_back(acc_log[w*RATIO + b]);
      check("t6_word", got[w], pack(tmp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
